// File: rtl/ssvep_freq_scheduler.sv
// ----------------------------------------------------------------------------
// ssvep_freq_scheduler
//
// Steps a visual stimulus through N_SLOTS reference frequencies and picks the
// slot with the largest averaged lock-in amplitude.
//
// For each slot the scheduler:
//   1. pulses lockin_clear for one cycle,
//   2. discards the first SETTLE results,
//   3. accumulates the next AVG results and averages them,
//   4. compares the average against the best so far.
// After the last slot it pulses done and publishes the winner.
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-high reset
//   start        one-cycle pulse that begins a scan (ignored while busy)
//   abort        one-cycle pulse that cancels a scan
//   amp_in       unsigned amplitude from the result calculator
//   amp_valid    amp_in qualifier, one cycle per result
//   m_sel        samples per reference period for the current slot
//   stim_en      visual stimulus enable
//   lockin_clear restarts the lock-in and mean filter
//   slot_idx     slot currently being measured
//   busy         FSM is not idle
//   done         one-cycle pulse when a scan completes
//   winner_idx   slot with the largest averaged amplitude
//   winner_amp   averaged amplitude of the winning slot
//   detect       detection flag, updated together with the winner
//
// Optional feature
//   SSVEP_SCHED_THRESH_EN : when defined, detect = (best_amp >= THRESH).
//                           When undefined, detect is set on every completed
//                           scan and THRESH has no effect.
// ----------------------------------------------------------------------------
module ssvep_freq_scheduler #(
  parameter int          N_SLOTS = 4,
  parameter int          M0      = 125,
  parameter int          M1      = 100,
  parameter int          M2      = 83,
  parameter int          M3      = 66,
  parameter int          SETTLE  = 2,
  parameter int          AVG     = 4,
  parameter logic [31:0] THRESH  = 32'd1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] amp_in,
  input  logic        amp_valid,
  output logic [9:0]  m_sel,
  output logic        stim_en,
  output logic        lockin_clear,
  output logic [1:0]  slot_idx,
  output logic        busy,
  output logic        done,
  output logic [1:0]  winner_idx,
  output logic [31:0] winner_amp,
  output logic        detect
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SETTLE,
    S_ACQ,
    S_NEXT,
    S_DONE
  } state_t;

  localparam int         AVG_SHIFT   = $clog2(AVG);
  localparam logic [1:0] LAST_SLOT   = 2'(N_SLOTS - 1);
  localparam logic [7:0] SETTLE_LAST = 8'((SETTLE > 0) ? (SETTLE - 1) : 0);
  localparam logic [7:0] AVG_LAST    = 8'(AVG - 1);
  localparam bit         SKIP_SETTLE = (SETTLE == 0);

  state_t      state;
  state_t      next_state;
  logic [35:0] acc;
  logic [7:0]  cnt;
  logic [31:0] best_amp;
  logic [1:0]  best_idx;
  logic [31:0] avg;

  // Average of the current slot; AVG is a power of two so a shift divides.
  assign avg = 32'(acc >> AVG_SHIFT);

  // Period selection follows the slot being measured; slot_idx only changes
  // on the NEXT->CLEAR edge, so m_sel is steady for the whole slot.
  always_comb begin
    m_sel = 10'(M0);
    case (slot_idx)
      2'd0:    m_sel = 10'(M0);
      2'd1:    m_sel = 10'(M1);
      2'd2:    m_sel = 10'(M2);
      default: m_sel = 10'(M3);
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and state-decoded outputs. Abort overrides every transition
  // out of a busy state; start together with abort in IDLE stays idle.
  always_comb begin
    next_state   = state;
    stim_en      = 1'b0;
    lockin_clear = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start && !abort) next_state = S_CLEAR;
      end
      S_CLEAR: begin
        stim_en      = 1'b1;
        lockin_clear = 1'b1;
        next_state   = SKIP_SETTLE ? S_ACQ : S_SETTLE;
      end
      S_SETTLE: begin
        stim_en = 1'b1;
        if (amp_valid && (cnt == SETTLE_LAST)) next_state = S_ACQ;
      end
      S_ACQ: begin
        stim_en = 1'b1;
        if (amp_valid && (cnt == AVG_LAST)) next_state = S_NEXT;
      end
      S_NEXT: begin
        stim_en    = 1'b1;
        next_state = (slot_idx == LAST_SLOT) ? S_DONE : S_CLEAR;
      end
      S_DONE: begin
        done       = 1'b1;
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
    if (abort && (state != S_IDLE)) next_state = S_IDLE;
  end

  // Datapath: slot index, result counter, accumulator, running best and the
  // published winner. Every update is gated by abort so an aborted cycle
  // (including a coincident amp_valid) leaves no trace.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_idx   <= 2'd0;
      acc        <= 36'd0;
      cnt        <= 8'd0;
      best_amp   <= 32'd0;
      best_idx   <= 2'd0;
      winner_idx <= 2'd0;
      winner_amp <= 32'd0;
      detect     <= 1'b0;
    end else if (!abort) begin
      case (state)
        S_IDLE: begin
          if (start) slot_idx <= 2'd0;
        end
        S_CLEAR: begin
          acc <= 36'd0;
          cnt <= 8'd0;
        end
        S_SETTLE: begin
          if (amp_valid) begin
            cnt <= (cnt == SETTLE_LAST) ? 8'd0 : cnt + 8'd1;
          end
        end
        S_ACQ: begin
          if (amp_valid) begin
            acc <= acc + {4'd0, amp_in};
            cnt <= cnt + 8'd1;
          end
        end
        S_NEXT: begin
          // Strict compare: on a tie the earlier (lower) slot keeps the lead.
          if ((slot_idx == 2'd0) || (avg > best_amp)) begin
            best_amp <= avg;
            best_idx <= slot_idx;
          end
          if (slot_idx != LAST_SLOT) slot_idx <= slot_idx + 2'd1;
        end
        S_DONE: begin
          winner_idx <= best_idx;
          winner_amp <= best_amp;
`ifdef SSVEP_SCHED_THRESH_EN
          detect     <= (best_amp >= THRESH);
`else
          detect     <= 1'b1;
`endif
        end
        default: begin
        end
      endcase
    end
  end

`ifndef SSVEP_SCHED_THRESH_EN
  // The threshold only matters when the detection compare is built in.
  logic unused_thresh;
  assign unused_thresh = ^THRESH;
`endif

endmodule
